mem_port_arbiter: RTL and testbench

//  Shares one unified memory port between the IF-stage fetch and the MEM-stage load/store of the 5-stage RISC-V pipeline.

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF-stage fetch and MEM-stage load/store.
// Data-first arbitration with a fetch anti-starvation bound and a per-transfer ack timeout.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_done,
    output logic [DW-1:0]   if_rdata,
    output logic            if_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_done,
    output logic [DW-1:0]   d_rdata,
    output logic            d_stall,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic            m_ack,
    input  logic [DW-1:0]   m_rdata,
    output logic            err,
    output logic [1:0]      dbg_state
);
    // Handshake: a requester holds x_req and its operands until x_done pulses, then
    // updates or drops x_req before the next edge; m_req stays high until m_ack is
    // sampled high on a rising edge, and m_rdata is taken in that same cycle.

    localparam int BW = DW / 8;
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
    localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [SW-1:0]   streak, streak_n;
    logic [TW-1:0]   tcnt, tcnt_n;
    logic            m_req_n, m_we_n;
    logic [AW-1:0]   m_addr_n;
    logic [DW-1:0]   m_wdata_n;
    logic [BW-1:0]   m_be_n;
    logic            if_done_n, d_done_n, err_n;
    logic [DW-1:0]   if_rdata_n, d_rdata_n;
    logic            data_win, timed_out;

    // Fetch is forced only when it is waiting and data has won MAX_DSTREAK times in a row.
    assign data_win  = d_req && !(if_req && (streak == STREAK_MAX));
    assign timed_out = !m_ack && (tcnt == TCNT_LAST);

    always_comb begin
        state_n    = state;
        streak_n   = streak;
        tcnt_n     = tcnt;
        m_req_n    = m_req;
        m_we_n     = m_we;
        m_addr_n   = m_addr;
        m_wdata_n  = m_wdata;
        m_be_n     = m_be;
        if_done_n  = 1'b0;
        d_done_n   = 1'b0;
        err_n      = 1'b0;
        if_rdata_n = if_rdata;
        d_rdata_n  = d_rdata;

        case (state)
            IDLE: begin
                if (data_win) begin
                    state_n   = GNT_D;
                    m_req_n   = 1'b1;
                    m_we_n    = d_we;
                    m_addr_n  = d_addr;
                    m_wdata_n = d_wdata;
                    m_be_n    = d_be;
                    tcnt_n    = '0;
                    if (!if_req)
                        streak_n = '0;
                    else if (streak != STREAK_MAX)
                        streak_n = streak + SW'(1);
                end else if (if_req) begin
                    state_n   = GNT_I;
                    m_req_n   = 1'b1;
                    m_we_n    = 1'b0;
                    m_addr_n  = if_addr;
                    m_wdata_n = '0;
                    m_be_n    = '1;
                    tcnt_n    = '0;
                    streak_n  = '0;
                end else begin
                    streak_n = '0;
                end
            end

            GNT_I, GNT_D: begin
                if (!m_ack)
                    tcnt_n = tcnt + TW'(1);
                if (m_ack || timed_out) begin
                    state_n = RESP;
                    m_req_n = 1'b0;
                    err_n   = timed_out;
                    if (state == GNT_I) begin
                        if_done_n  = 1'b1;
                        if_rdata_n = timed_out ? '0 : m_rdata;
                    end else begin
                        d_done_n = 1'b1;
                        // Stores leave the last load value in place.
                        if (timed_out)
                            d_rdata_n = '0;
                        else if (!m_we)
                            d_rdata_n = m_rdata;
                    end
                end
            end

            RESP: state_n = IDLE;

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            streak   <= '0;
            tcnt     <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_be     <= '0;
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            err      <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            state    <= state_n;
            streak   <= streak_n;
            tcnt     <= tcnt_n;
            m_req    <= m_req_n;
            m_we     <= m_we_n;
            m_addr   <= m_addr_n;
            m_wdata  <= m_wdata_n;
            m_be     <= m_be_n;
            if_done  <= if_done_n;
            d_done   <= d_done_n;
            err      <= err_n;
            if_rdata <= if_rdata_n;
            d_rdata  <= d_rdata_n;
        end
    end

    assign if_stall  = if_req & ~if_done;
    assign d_stall   = d_req & ~d_done;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed grant orders and data values.
module tb_mem_port_arbiter;
    localparam int TMO  = 8;
    localparam int MAXS = 4;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        err;
    logic [1:0]  dbg_state;

    mem_port_arbiter #(
        .AW(32), .DW(32), .MAX_DSTREAK(MAXS), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ack(m_ack), .m_rdata(m_rdata), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected end within 500000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h0010_0093;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // ---------------- memory responder ----------------
    int ack_dly    = 1;
    bit ack_off    = 1'b0;
    bit stray_ack  = 1'b0;

    initial begin
        int wcnt;
        wcnt    = 0;
        m_ack   = 1'b0;
        m_rdata = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #1;
            if (m_req && !ack_off) begin
                m_ack   = (wcnt == ack_dly);
                m_rdata = (wcnt == ack_dly) ? mem_word(m_addr) : 32'hDEAD_BEEF;
                wcnt++;
            end else begin
                m_ack   = m_req ? 1'b0 : stray_ack;
                m_rdata = 32'hDEAD_BEEF;
                wcnt    = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    // One transfer in flight at a time; after it ends there is one response cycle.
    bit          mb_busy = 0, mb_isd = 0, mb_we = 0, mb_resp = 0;
    int          mb_wait = 0, mb_streak = 0;
    logic        e_m_req = 0, e_m_we = 0, e_if_done = 0, e_d_done = 0, e_err = 0;
    logic [31:0] e_m_addr = 0, e_m_wdata = 0, e_if_rdata = 0, e_d_rdata = 0;
    logic [3:0]  e_m_be = 0;

    task model_finish(input bit to, input logic [31:0] rd);
        mb_busy <= 1'b0;
        mb_resp <= 1'b1;
        e_m_req <= 1'b0;
        e_err   <= to;
        if (!mb_isd) begin
            e_if_done  <= 1'b1;
            e_if_rdata <= to ? 32'h0 : rd;
        end else begin
            e_d_done <= 1'b1;
            if (to) e_d_rdata <= 32'h0;
            else if (!mb_we) e_d_rdata <= rd;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mb_busy <= 0; mb_isd <= 0; mb_we <= 0; mb_resp <= 0; mb_wait <= 0; mb_streak <= 0;
            e_m_req <= 0; e_m_we <= 0; e_m_addr <= 0; e_m_wdata <= 0; e_m_be <= 0;
            e_if_done <= 0; e_d_done <= 0; e_err <= 0; e_if_rdata <= 0; e_d_rdata <= 0;
        end else begin
            e_if_done <= 1'b0;
            e_d_done  <= 1'b0;
            e_err     <= 1'b0;
            if (mb_resp) begin
                mb_resp <= 1'b0;
            end else if (mb_busy) begin
                if (m_ack) model_finish(1'b0, m_rdata);
                else if (mb_wait + 1 == TMO) model_finish(1'b1, 32'h0);
                else mb_wait <= mb_wait + 1;
            end else if (d_req && !(if_req && mb_streak == MAXS)) begin
                mb_busy <= 1'b1; mb_isd <= 1'b1; mb_we <= d_we; mb_wait <= 0;
                e_m_req <= 1'b1; e_m_we <= d_we; e_m_addr <= d_addr;
                e_m_wdata <= d_wdata; e_m_be <= d_be;
                mb_streak <= if_req ? ((mb_streak < MAXS) ? mb_streak + 1 : MAXS) : 0;
            end else if (if_req) begin
                mb_busy <= 1'b1; mb_isd <= 1'b0; mb_we <= 1'b0; mb_wait <= 0;
                e_m_req <= 1'b1; e_m_we <= 1'b0; e_m_addr <= if_addr; e_m_be <= 4'hF;
                mb_streak <= 0;
            end else begin
                mb_streak <= 0;
            end
        end
    end

    // ---------------- per-cycle compare and monitor ----------------
    logic [31:0] grant_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] g_wdata = 0;
    logic        g_we = 0;
    logic [3:0]  g_be = 0;
    int          if_done_cnt = 0, d_done_cnt = 0, run = 0, last_run = 0;
    logic        mreq_prev = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("m_req", 32'(m_req), 32'(e_m_req));
                if (e_m_req) begin
                    check("m_addr", m_addr, e_m_addr);
                    check("m_we", 32'(m_we), 32'(e_m_we));
                    check("m_be", 32'(m_be), 32'(e_m_be));
                    if (mb_isd) check("m_wdata", m_wdata, e_m_wdata);
                end
                check("if_done", 32'(if_done), 32'(e_if_done));
                check("d_done", 32'(d_done), 32'(e_d_done));
                check("err", 32'(err), 32'(e_err));
                check("if_rdata", if_rdata, e_if_rdata);
                check("d_rdata", d_rdata, e_d_rdata);
                check("if_stall", 32'(if_stall), 32'(if_req & ~e_if_done));
                check("d_stall", 32'(d_stall), 32'(d_req & ~e_d_done));
            end
            if (m_req && !mreq_prev) begin
                grant_q.push_back(m_addr);
                g_we = m_we; g_be = m_be; g_wdata = m_wdata;
            end
            if (m_req) run++;
            else if (run != 0) begin last_run = run; run = 0; end
            mreq_prev = m_req;
            if (if_done) if_done_cnt++;
            if (d_done) d_done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dop_t;
    dop_t        d_ops[$];
    logic [31:0] last_i_rdata = 0, last_d_rdata = 0;
    logic        last_d_err = 0;

    task automatic wait_if_done();
        bit seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (if_done) begin seen = 1'b1; last_i_rdata = if_rdata; break; end
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL if_done_wait: got no pulse expected pulse within 400 cycles");
        end
    endtask

    task automatic wait_d_done();
        bit seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (d_done) begin seen = 1'b1; last_d_rdata = d_rdata; last_d_err = err; break; end
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL d_done_wait: got no pulse expected pulse within 400 cycles");
        end
    endtask

    // Callers enter just after a rising edge.
    task automatic fetch_seq(input logic [31:0] base, input int n);
        if_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            if_addr = base + 32'(4 * i);
            wait_if_done();
        end
        if_req = 1'b0;
    endtask

    task automatic data_seq();
        dop_t op;
        d_req = 1'b1;
        while (d_ops.size() > 0) begin
            op      = d_ops.pop_front();
            d_we    = op.we;
            d_addr  = op.addr;
            d_wdata = op.wdata;
            d_be    = op.be;
            wait_d_done();
        end
        d_req = 1'b0;
    endtask

    task automatic push_op(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        dop_t op;
        op.we = we; op.addr = a; op.wdata = wd; op.be = be;
        d_ops.push_back(op);
    endtask

    task automatic check_grants(input string name);
        check({name, "_count"}, 32'(grant_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && grant_q.size() > 0)
            check({name, "_addr"}, grant_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        grant_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int c0;
        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        @(posedge clk); #1;
        cmp_en = 1'b1;
        idle(2);
        check("rst_m_req", 32'(m_req), 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b1;
        idle(2);

        // Fetch only, ack two cycles after m_req.
        ack_dly = 2;
        grant_q.delete();
        c0 = if_done_cnt;
        fetch_seq(32'h10, 1);
        idle(3);
        check("fetch_rdata", last_i_rdata, 32'h0010_0093);
        check("fetch_m_be", 32'(g_be), 32'hF);
        check("fetch_m_we", 32'(g_we), 32'd0);
        check("fetch_done_cnt", 32'(if_done_cnt - c0), 32'd1);
        exp_q.push_back(32'h10);
        check_grants("fetch_gnt");

        // Simultaneous fetch and load: data first.
        ack_dly = 1;
        push_op(1'b0, 32'h100, 32'h0, 4'hF);
        fork
            fetch_seq(32'h40, 1);
            data_seq();
        join
        idle(2);
        check("simul_d_rdata", last_d_rdata, 32'h5B5A_0100);
        check("simul_if_rdata", last_i_rdata, 32'h5A1A_0040);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h40);
        check_grants("simul_gnt");

        // Store with stray acks outside the grant window.
        stray_ack = 1'b1;
        push_op(1'b1, 32'h200, 32'hFFFF_FFFF, 4'h3);
        data_seq();
        stray_ack = 1'b0;
        idle(2);
        check("store_m_we", 32'(g_we), 32'd1);
        check("store_m_wdata", g_wdata, 32'hFFFF_FFFF);
        check("store_m_be", 32'(g_be), 32'h3);
        check("store_d_rdata", last_d_rdata, 32'h5B5A_0100);
        exp_q.push_back(32'h200);
        check_grants("store_gnt");

        // Starvation: back-to-back stores with a waiting fetch.
        for (int i = 0; i < 6; i++)
            push_op(1'b1, 32'h400 + 32'(4 * i), 32'(i + 1), 4'hF);
        fork
            fetch_seq(32'h80, 1);
            data_seq();
        join
        idle(2);
        exp_q.push_back(32'h400); exp_q.push_back(32'h404);
        exp_q.push_back(32'h408); exp_q.push_back(32'h40C);
        exp_q.push_back(32'h80);
        exp_q.push_back(32'h410); exp_q.push_back(32'h414);
        check_grants("starve_gnt");

        // Timeout on a load.
        ack_off = 1'b1;
        push_op(1'b0, 32'h300, 32'h0, 4'hF);
        data_seq();
        check("tmo_err", 32'(last_d_err), 32'd1);
        check("tmo_d_rdata", last_d_rdata, 32'd0);
        idle(1);
        check("tmo_state_idle", 32'(dbg_state), 32'd0);
        check("tmo_mreq_cycles", 32'(last_run), 32'(TMO));
        ack_off = 1'b0;
        exp_q.push_back(32'h300);
        check_grants("tmo_gnt");

        // Reset while a load waits for its ack.
        ack_off = 1'b1;
        c0 = d_done_cnt;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_be = 4'hF;
        idle(2);
        check("rst_mid_mreq_before", 32'(m_req), 32'd1);
        idle(2);
        reset = 1'b0;
        #1;
        check("rst_mid_mreq", 32'(m_req), 32'd0);
        check("rst_mid_done", 32'(d_done), 32'd0);
        check("rst_mid_state", 32'(dbg_state), 32'd0);
        d_req = 1'b0;
        ack_off = 1'b0;
        idle(1);
        reset = 1'b1;
        idle(2);
        check("rst_mid_done_cnt", 32'(d_done_cnt - c0), 32'd0);
        grant_q.delete();
        push_op(1'b0, 32'h600, 32'h0, 4'hF);
        data_seq();
        idle(2);
        check("post_rst_d_rdata", last_d_rdata, 32'h5C5A_0600);
        check("post_rst_done_cnt", 32'(d_done_cnt - c0), 32'd1);
        exp_q.push_back(32'h600);
        check_grants("post_rst_gnt");

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
